// File: rtl/alu_iterative.sv
// rtl/alu_iterative.sv - multi-cycle signed ALU, SLICE bits per clock, LSB slice first
module alu_iterative #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  input  logic [2:0]       bonus_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b0111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [3:0]       op_q, op_d;
  logic [2:0]       mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, equal_q, equal_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [SLICE-1:0] a_s, b_s, b_eff, slice_res;
  logic [SLICE:0]   sum_w;
  logic             is_sub, slice_cout, cin_msb, slice_eq, ovf_w, less, set;
  logic             accept, arith;
  logic [WIDTH-1:0] acc_next, final_res;

  // Slice datapath: operates on the low SLICE bits of the shifting operand registers.
  always_comb begin
    a_s        = a_q[SLICE-1:0];
    b_s        = b_q[SLICE-1:0];
    is_sub     = (op_q == OP_SUB) || (op_q == OP_SLT);
    b_eff      = is_sub ? ~b_s : b_s;
    sum_w      = {1'b0, a_s} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_q};
    slice_cout = sum_w[SLICE];
    cin_msb    = sum_w[SLICE-1] ^ a_s[SLICE-1] ^ b_eff[SLICE-1];
    ovf_w      = cin_msb ^ slice_cout;
    less       = sum_w[SLICE-1] ^ ovf_w;
    slice_eq   = equal_q & (a_s == b_s);
    arith      = (op_q == OP_ADD) || (op_q == OP_SUB);

    case (op_q)
      OP_AND:                 slice_res = a_s & b_s;
      OP_OR:                  slice_res = a_s | b_s;
      OP_ADD, OP_SUB, OP_SLT: slice_res = sum_w[SLICE-1:0];
      OP_NOR:                 slice_res = ~(a_s | b_s);
      OP_NAND:                slice_res = ~(a_s & b_s);
      default:                slice_res = '0;
    endcase

    case (mode_q)
      3'b000:  set = less;
      3'b001:  set = ~(less | slice_eq);
      3'b010:  set = less | slice_eq;
      3'b011:  set = ~less;
      3'b110:  set = slice_eq;
      3'b100:  set = ~slice_eq;
      default: set = 1'b0;
    endcase

    acc_next  = {slice_res, acc_q[WIDTH-1:SLICE]};
    final_res = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, set} : acc_next;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    op_d     = op_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    equal_d  = equal_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;

    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        acc_d   = acc_next;
        carry_d = slice_cout;
        equal_d = slice_eq;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = final_res;
          zero_d   = (final_res == '0);
          cout_d   = arith & slice_cout;
          ovf_d    = arith & ovf_w;
        end
      end
      DONE: if (out_ready) state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d     = src1;
      b_d     = src2;
      op_d    = ALU_control;
      mode_d  = bonus_control;
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = (ALU_control == OP_SUB) || (ALU_control == OP_SLT);
      equal_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      mode_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      equal_q  <= 1'b1;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      equal_q  <= equal_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_iterative.sv
// tb/tb_alu_iterative.sv - scoreboard bench for alu_iterative (WIDTH=32, SLICE=4)
module tb_alu_iterative;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] src1 = '0, src2 = '0;
  logic [3:0]  ALU_control = '0;
  logic [2:0]  bonus_control = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero, cout, overflow;

  alu_iterative #(.WIDTH(32), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .ALU_control(ALU_control), .bonus_control(bonus_control),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] r;
    logic        z, c, o;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every result handshake is compared against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".result"}, result, e.r);
        check({e.name, ".zero"}, {31'd0, zero}, {31'd0, e.z});
        check({e.name, ".cout"}, {31'd0, cout}, {31'd0, e.c});
        check({e.name, ".overflow"}, {31'd0, overflow}, {31'd0, e.o});
      end
    end
  end

  task automatic issue(input string name, input logic [3:0] op, input logic [2:0] mode,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                       input logic ez, input logic ec, input logic eo, input bit push);
    int n;
    exp_t e;
    src1 = a; src2 = b; ALU_control = op; bonus_control = mode; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check({name, ".accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    src1 = 32'hDEADBEEF; src2 = 32'h0BADF00D; ALU_control = 4'b1111; bonus_control = 3'b111;
    if (push) begin
      e.name = name; e.r = er; e.z = ez; e.c = ec; e.o = eo;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check({name, ".latency"}, lat, 32'd8);
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [2:0] mode,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                        input logic ez, input logic ec, input logic eo);
    issue(name, op, mode, a, b, er, ez, ec, eo, 1'b1);
    wait_done(name);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs;
    repeat (2) @(posedge clk);
    #1;
    check("reset.result", result, 32'd0);
    check("reset.zero", {31'd0, zero}, 32'd0);
    check("reset.out_valid", {31'd0, out_valid}, 32'd0);
    check("reset.in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_ovf",   4'b0010, 3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1);
    run_op("sub_eq",    4'b0110, 3'b000, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0);
    run_op("add_wrap",  4'b0010, 3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0);
    run_op("sub_neg",   4'b0110, 3'b000, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 0);
    run_op("slt_lt",    4'b0111, 3'b000, 32'h80000000, 32'h00000001, 32'h00000001, 0, 0, 0);
    run_op("slt_gt",    4'b0111, 3'b001, 32'h80000000, 32'h00000001, 32'h00000000, 1, 0, 0);
    run_op("slt_ge",    4'b0111, 3'b011, 32'h80000000, 32'h00000001, 32'h00000000, 1, 0, 0);
    run_op("slt_eq",    4'b0111, 3'b110, 32'h00001234, 32'h00001234, 32'h00000001, 0, 0, 0);
    run_op("slt_le_eq", 4'b0111, 3'b010, 32'h00001234, 32'h00001234, 32'h00000001, 0, 0, 0);
    run_op("slt_ne_eq", 4'b0111, 3'b100, 32'h00001234, 32'h00001234, 32'h00000000, 1, 0, 0);
    run_op("slt_gt_p",  4'b0111, 3'b001, 32'h00000005, 32'h00000003, 32'h00000001, 0, 0, 0);
    run_op("slt_le_p",  4'b0111, 3'b010, 32'h00000005, 32'h00000003, 32'h00000000, 1, 0, 0);
    run_op("slt_m101",  4'b0111, 3'b101, 32'h80000000, 32'h00000001, 32'h00000000, 1, 0, 0);
    run_op("undef_op",  4'b1111, 3'b000, 32'h12345678, 32'h11111111, 32'h00000000, 1, 0, 0);
    run_op("and",       4'b0000, 3'b000, 32'hF0F0A5A5, 32'h0FF05A5A, 32'h00F00000, 0, 0, 0);
    run_op("or",        4'b0001, 3'b000, 32'hF0F0A5A5, 32'h0FF05A5A, 32'hFFF0FFFF, 0, 0, 0);
    run_op("nor",       4'b1100, 3'b000, 32'hF0F0A5A5, 32'h0FF05A5A, 32'h000F0000, 0, 0, 0);
    run_op("nand",      4'b1101, 3'b000, 32'hF0F0A5A5, 32'h0FF05A5A, 32'hFF0FFFFF, 0, 0, 0);

    // Backpressure then back-to-back accept on the releasing edge.
    out_ready = 1'b0;
    issue("bp_first", 4'b0010, 3'b000, 32'h00000001, 32'h00000002, 32'h00000003, 0, 0, 0, 1'b1);
    wait_done("bp_first");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.out_valid", {31'd0, out_valid}, 32'd1);
      check("bp.result", result, 32'h00000003);
      check("bp.in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.in_ready_release", {31'd0, in_ready}, 32'd1);
    issue("bp_second", 4'b0110, 3'b000, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 0, 1'b1);
    wait_done("bp_second");
    @(posedge clk); #1;

    // Reset mid-RUN discards the operation.
    issue("rst_abort", 4'b0010, 3'b000, 32'h00000010, 32'h00000020, 32'h0, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.result", result, 32'd0);
    check("rst.zero", {31'd0, zero}, 32'd0);
    check("rst.cout", {31'd0, cout}, 32'd0);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) highs++;
    end
    check("rst.no_out_valid", highs, 32'd0);
    run_op("post_rst",  4'b0010, 3'b000, 32'h00000010, 32'h00000020, 32'h00000030, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
